fifo_dyser_in: RTL and testbench
================================

Name: fifo_dyser_in

Overview:
- Input-side FIFO of the overlay. It accepts words pushed by the core and feeds the input bridge and switch fabric.
- It is the counterpart of the output bridge FIFO: the core-side producer here is governed by credits that this block returns.
- Register-array circular buffer with show-ahead read; no vendor FIFO IP.
- Downstream stall via busy_in; upstream flow control via one-cycle credit_out pulses, one per freed entry.

Parameters:
ID, 0, instance identifier, informational only.
DEPTH, 16, number of entries; must be a power of two, at least 2.
AW, 4, pointer width; equals log2(DEPTH).

Ports:
clk  input  1  clock, all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
d_in  input  `DATA_WIDTH+1  word from core; bit `DATA_WIDTH is the control/predicate bit, carried untouched.
wr  input  1  core write strobe; one word per cycle.
d_out  output  `DATA_WIDTH+1  head-of-queue word (show-ahead).
valid_out  output  1  d_out holds a valid word.
busy_in  input  1  fabric stall; the word is consumed when valid_out & ~busy_in.
credit_out  output  1  one-cycle pulse returning one credit to the core.
empty  output  1  count == 0.
full  output  1  count == DEPTH.
count  output  AW+1  current occupancy, 0..DEPTH.
overflow  output  1  sticky write-while-full flag (see Optional Feature).

Behaviour:
Reset values:
- rd_ptr = 0, wr_ptr = 0, count = 0.
- valid_out = 0, credit_out = 0, overflow = 0, empty = 1, full = 0.
- d_out is don't-care while valid_out = 0. Memory contents are not reset.
- Reset mid-operation discards all entries; no credits are returned for them. The core must reinitialise its credit counter to DEPTH on the same reset.

Pop and push rules:
- pop = valid_out & ~busy_in.
- push = wr & (~full | pop). A write to a full FIFO is accepted when a pop happens in the same cycle.
- On push: mem[wr_ptr] <= d_in, then wr_ptr += 1. On pop: rd_ptr += 1. Pointers wrap modulo DEPTH through natural AW-bit overflow.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.

Output side:
- d_out = mem[rd_ptr], combinational read of the register array.
- valid_out = ~empty.
- Latency: a word written at cycle N is visible on d_out/valid_out at N+1. There is no same-cycle bypass from d_in.
- Simultaneous push and pop when empty is impossible because valid_out = 0. The word appears at N+1.

Credits:
- credit_out is registered and equals pop delayed by one cycle.
- Exactly one pulse per consumed word. The number of pulses between resets equals the number of pops.
- The core starts with DEPTH credits. It spends one per wr and regains one per credit_out.

Overflow:
- A dropped write is wr & full & ~pop. The dropped word is discarded and no state changes except the flag.

Control states (implicit in count): EMPTY (count = 0), PARTIAL, FULL (count = DEPTH).
- EMPTY → PARTIAL on push.
- PARTIAL → FULL on push without pop at count = DEPTH-1.
- FULL → PARTIAL on pop without push.
- PARTIAL → EMPTY on pop without push at count = 1.
- Push and pop together: state held.

Optional Feature:
Macro `FIFO_IN_OVERFLOW_CHK_EN:
- Defined: overflow is set on any dropped write and stays set until rst. In simulation, a $display reports ID and the time of the first drop.
- Undefined: overflow is tied 0 and dropped writes are silently ignored. The rest of the behaviour is identical.

Test Plan:
- Reset then single write of 0x1_0000ABCD at cycle 1, busy_in = 0: valid_out = 1 and d_out = 0x1_0000ABCD at cycle 2; credit_out pulses at cycle 3; count returns to 0.
- Hold busy_in = 1 and write 16 words 0..15: full = 1, count = 16, no credit_out. Then release busy_in: 16 pops in order 0..15 and 16 credit_out pulses, each one cycle after its pop.
- Full with busy_in = 0, and wr of 0x77 in the same cycle: write accepted, count stays 16, 0x77 is read last with no loss.
- Full, busy_in = 1, wr of 0x55: word dropped, count = 16. With the macro defined overflow = 1 until rst; without it overflow = 0.
- Push and pop every cycle for 40 cycles with an incrementing pattern: pointers wrap twice, the output sequence matches the input exactly, and count stays constant.
- Reset asserted at count = 9: next cycle count = 0, empty = 1, valid_out = 0, and no credit_out pulses follow.

Source files
------------

// File: rtl/fifo_dyser_in_if.sv
// Core-side and fabric-side signal bundle for the fifo_dyser_in input FIFO.
// Data width follows `DATA_WIDTH (default 32), plus one control/predicate bit.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface fifo_dyser_in_if #(parameter int AW = 4);
  logic [`DATA_WIDTH:0] d_in;
  logic                 wr;
  logic [`DATA_WIDTH:0] d_out;
  logic                 valid_out;
  logic                 busy_in;
  logic                 credit_out;
  logic                 empty;
  logic                 full;
  logic [AW:0]          count;
  logic                 overflow;

  modport master (
    output d_in, wr, busy_in,
    input  d_out, valid_out, credit_out, empty, full, count, overflow
  );

  modport slave (
    input  d_in, wr, busy_in,
    output d_out, valid_out, credit_out, empty, full, count, overflow
  );
endinterface

// File: rtl/fifo_dyser_in.sv
// Show-ahead register-array FIFO feeding the input bridge; returns one credit per pop.
// Optional sticky overflow detection: define FIFO_IN_OVERFLOW_CHK_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module fifo_dyser_in #(
  parameter int ID    = 0,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic            clk,
  input  logic            rst,
  fifo_dyser_in_if.slave  bus
);
  localparam int DW = `DATA_WIDTH;

  logic [DW:0]   r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic          r_credit;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = ~w_empty & ~bus.busy_in;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_push  = bus.wr & (~w_full | w_pop);
  assign w_drop  = bus.wr & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.d_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_credit <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push & ~w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_pop & ~w_push) r_count <= r_count - (AW+1)'(1);
      r_credit <= w_pop;
    end
  end

`ifdef FIFO_IN_OVERFLOW_CHK_EN
  logic r_overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
`ifndef SYNTHESIS
      if (!r_overflow) $display("fifo_dyser_in[%0d]: first dropped write at %0t", ID, $time);
`endif
      r_overflow <= 1'b1;
    end
  end

  assign bus.overflow = r_overflow;
`else
  logic w_overflow;
  logic w_unused;

  assign w_overflow   = 1'b0;
  assign w_unused     = w_drop;
  assign bus.overflow = w_overflow;
`endif

  assign bus.d_out      = r_mem[r_rd_ptr];
  assign bus.valid_out  = ~w_empty;
  assign bus.credit_out = r_credit;
  assign bus.empty      = w_empty;
  assign bus.full       = w_full;
  assign bus.count      = r_count;
endmodule

// File: tb/tb_fifo_dyser_in.sv
// Scoreboard bench for fifo_dyser_in: directed test-plan sequences plus random traffic.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_fifo_dyser_in;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = `DATA_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_dyser_in_if #(.AW(AW)) bus ();

  fifo_dyser_in #(.ID(3), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  logic [DW:0] exp_q[$];
  logic        exp_credit = 1'b0;
  logic        exp_ov     = 1'b0;
  bit          m_init     = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
    end
  endfunction

  // Monitor: compare current DUT outputs against the queue model, then advance
  // the model by the rules for the upcoming rising edge.
  always @(negedge clk) begin
    bit pop;
    bit push;
    if (m_init) begin
      chk("valid_out",  64'(bus.valid_out),  64'(exp_q.size() != 0));
      chk("empty",      64'(bus.empty),      64'(exp_q.size() == 0));
      chk("full",       64'(bus.full),       64'(exp_q.size() == DEPTH));
      chk("count",      64'(bus.count),      64'(exp_q.size()));
      chk("credit_out", 64'(bus.credit_out), 64'(exp_credit));
      chk("overflow",   64'(bus.overflow),   64'(exp_ov));
      if (exp_q.size() != 0) chk("d_out", 64'(bus.d_out), 64'(exp_q[0]));
    end
    if (rst) begin
      exp_q.delete();
      exp_credit = 1'b0;
      exp_ov     = 1'b0;
      m_init     = 1'b1;
    end else if (m_init) begin
      pop  = (exp_q.size() != 0) && !bus.busy_in;
      push = bus.wr && ((exp_q.size() < DEPTH) || pop);
      if (pop)  void'(exp_q.pop_front());
      if (push) exp_q.push_back(bus.d_in);
`ifdef FIFO_IN_OVERFLOW_CHK_EN
      if (bus.wr && !push) exp_ov = 1'b1;
`endif
      exp_credit = pop;
    end
  end

  task automatic drive(input bit w, input logic [DW:0] d, input bit b, input bit r = 1'b0);
    rst         = r;
    bus.wr      = w;
    bus.d_in    = d;
    bus.busy_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit b = 1'b0);
    for (int i = 0; i < n; i++) drive(1'b0, '0, b);
  endtask

  initial begin
    logic [DW:0] word;
    bus.wr = 1'b0; bus.d_in = '0; bus.busy_in = 1'b0;
    #1;
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);

    // Single write with control bit set.
    word = '0; word[DW] = 1'b1; word[31:0] = 32'h0000ABCD;
    drive(1'b1, word, 1'b0);
    idle(4);

    // Fill under stall, drop one, then a write accepted by a simultaneous pop.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, (DW+1)'(i), 1'b1);
    #3 chk("fill_count", 64'(bus.count), 64'(DEPTH));
    chk("fill_full", 64'(bus.full), 64'd1);
    drive(1'b1, (DW+1)'('h55), 1'b1);
    drive(1'b1, (DW+1)'('h77), 1'b0);
    idle(20);

    drive(1'b0, '0, 1'b0, 1'b1);

    // Continuous push/pop with an incrementing pattern.
    for (int i = 0; i < 41; i++) drive(1'b1, (DW+1)'(100 + i), 1'b0);
    idle(3);

    // Reset with nine entries queued.
    for (int i = 0; i < 9; i++) drive(1'b1, (DW+1)'(200 + i), 1'b1);
    #3 chk("pre_rst_count", 64'(bus.count), 64'd9);
    drive(1'b0, '0, 1'b0, 1'b1);
    idle(4);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      word = {1'($urandom_range(1, 0)), 32'($urandom())};
      drive(1'($urandom_range(1, 0)), word, ($urandom_range(3, 0) == 0));
    end
    idle(DEPTH + 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
